sumador_arbitro: RTL and testbench

Two-requester front-end for the pipelined 4-bit adder (`sumador` datapath, `sum30_dd_out`/`idx_dd_out` outputs). It round-robin arbitrates operand pairs from two clients onto the adder's single input port, tags each issue in `idx`, and routes each returning sum to the client that issued it. It also flags out-of-order or corrupted tags. It sits directly in front of the adder; the adder itself is unchanged.

---
 rtl/sumador_arbitro_pkg.sv | 36 +++
 rtl/sumador_arbitro_if.sv | 55 +++++
 rtl/sumador_arbitro_rr_arb2.sv | 26 ++
 rtl/sumador_arbitro.sv | 134 +++++++++++++
 tb/tb_sumador_arbitro.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sumador_arbitro_pkg.sv
// -----------------------------------------------------------------------------
// sumador_pkg
// Shared constants and types for the two-client front-end of the pipelined
// 4-bit adder. Contents:
//   - tag field positions inside idx / idx_dd_out
//   - operand and sequence-number widths
//   - default adder latency
//   - make_tag(): builds a valid issue tag from a client id and sequence number
// -----------------------------------------------------------------------------
package sumador_pkg;

  localparam int DATA_W      = 4;
  localparam int SEQ_W       = 2;

  // Tag layout: {valid, client id, seq[1:0]}
  localparam int IDX_VLD     = 3;
  localparam int IDX_ID      = 2;
  localparam int IDX_SEQ_HI  = 1;
  localparam int IDX_SEQ_LO  = 0;

  localparam int LAT_DEFAULT = 2;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SEQ_W-1:0]   seq_t;
  typedef logic [IDX_VLD:0]   tag_t;

  function automatic tag_t make_tag(input logic id, input seq_t seq);
    tag_t t;
    t                         = '0;
    t[IDX_VLD]                = 1'b1;
    t[IDX_ID]                 = id;
    t[IDX_SEQ_HI:IDX_SEQ_LO]  = seq;
    return t;
  endfunction

endpackage

// File: rtl/sumador_arbitro_if.sv
// -----------------------------------------------------------------------------
// sumador_arbitro_if
// Bundles the client request/response handshakes and the adder-side port of
// the arbitration front-end.
//   Client side : reqN_valid/reqN_a/reqN_b in, reqN_ready out,
//                 rspN_valid/rspN_sum out (one-cycle pulse, no back-pressure)
//   Adder side  : dataA/dataB/idx out (registered), sum30_dd_out/idx_dd_out in
//   Status      : seq_error out (sticky tag mismatch)
// Modport slave is the arbiter itself; master is the environment (clients
// plus adder) that drives the arbiter's inputs.
// -----------------------------------------------------------------------------
interface sumador_arbitro_if;
  import sumador_pkg::*;

  logic  req0_valid;
  logic  req1_valid;
  data_t req0_a;
  data_t req0_b;
  data_t req1_a;
  data_t req1_b;
  logic  req0_ready;
  logic  req1_ready;

  logic  rsp0_valid;
  logic  rsp1_valid;
  data_t rsp0_sum;
  data_t rsp1_sum;

  data_t dataA;
  data_t dataB;
  tag_t  idx;
  data_t sum30_dd_out;
  tag_t  idx_dd_out;

  logic  seq_error;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  sum30_dd_out, idx_dd_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_sum, rsp1_sum,
    output dataA, dataB, idx,
    output seq_error
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output sum30_dd_out, idx_dd_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_sum, rsp1_sum,
    input  dataA, dataB, idx,
    input  seq_error
  );

endinterface

// File: rtl/sumador_arbitro_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant, purely combinational.
//   req[1:0]    in   request per client
//   last_grant  in   client id granted on the most recent transfer
//   gnt[1:0]    out  one-hot grant (all zero when nobody requests)
// A lone requester always wins; on a tie the client that did not win last
// time is granted.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sumador_arbitro.sv
// -----------------------------------------------------------------------------
// sumador_arbitro
// Front-end that shares the pipelined 4-bit adder between two clients.
// Grants one operand pair per cycle (round robin), tags it with
// {valid, client, seq}, and steers each returning sum back to its issuer.
// Returned tags are checked against a per-client expected sequence number;
// any mismatch sets the sticky seq_error.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    sumador_arbitro_if.slave (client handshakes + adder port)
// Parameter LAT: adder latency in clock edges (1..3).
// -----------------------------------------------------------------------------
module sumador_arbitro
  import sumador_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  sumador_arbitro_if.slave  bus
);

  // Drain counter is loaded with the adder latency so that results still in
  // flight from before reset are discarded rather than delivered.
  localparam logic [1:0] DRAIN_INIT = 2'(LAT);

  logic [1:0] gnt;
  logic [1:0] ready;
  logic       xfer;
  logic       sel;

  logic       last_grant_q, last_grant_d;
  seq_t       iss_seq_q [2];
  seq_t       iss_seq_d [2];
  data_t      dataA_q, dataA_d;
  data_t      dataB_q, dataB_d;
  tag_t       idx_q, idx_d;

  logic       ret_take;
  logic       ret_id;
  seq_t       ret_seq_q [2];
  seq_t       ret_seq_d [2];
  logic [1:0] rsp_vld_q, rsp_vld_d;
  data_t      rsp_sum_q [2];
  data_t      rsp_sum_d [2];
  logic       seq_err_q, seq_err_d;
  logic [1:0] drain_q, drain_d;

  rr_arb2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Grants are suppressed asynchronously while reset is held.
  assign ready = gnt & {2{~reset}};
  assign xfer  = |ready;
  assign sel   = ready[1];

  always_comb begin
    last_grant_d = last_grant_q;
    iss_seq_d    = iss_seq_q;
    dataA_d      = '0;
    dataB_d      = '0;
    idx_d        = '0;
    if (xfer) begin
      dataA_d        = sel ? bus.req1_a : bus.req0_a;
      dataB_d        = sel ? bus.req1_b : bus.req0_b;
      idx_d          = make_tag(sel, iss_seq_q[sel]);
      iss_seq_d[sel] = iss_seq_q[sel] + seq_t'(1);
      last_grant_d   = sel;
    end
  end

  assign ret_id   = bus.idx_dd_out[IDX_ID];
  assign ret_take = bus.idx_dd_out[IDX_VLD] && (drain_q == 2'd0);

  always_comb begin
    rsp_vld_d = 2'b00;
    rsp_sum_d = rsp_sum_q;
    ret_seq_d = ret_seq_q;
    seq_err_d = seq_err_q;
    if (ret_take) begin
      rsp_vld_d[ret_id] = 1'b1;
      rsp_sum_d[ret_id] = bus.sum30_dd_out;
      ret_seq_d[ret_id] = ret_seq_q[ret_id] + seq_t'(1);
      // A bad tag is still delivered; the flag only records that ordering
      // or tag integrity was lost somewhere in the adder path.
      if (bus.idx_dd_out[IDX_SEQ_HI:IDX_SEQ_LO] != ret_seq_q[ret_id]) begin
        seq_err_d = 1'b1;
      end
    end
  end

  assign drain_d = (drain_q == 2'd0) ? 2'd0 : drain_q - 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      iss_seq_q    <= '{default: '0};
      dataA_q      <= '0;
      dataB_q      <= '0;
      idx_q        <= '0;
      ret_seq_q    <= '{default: '0};
      rsp_vld_q    <= 2'b00;
      rsp_sum_q    <= '{default: '0};
      seq_err_q    <= 1'b0;
      drain_q      <= DRAIN_INIT;
    end else begin
      last_grant_q <= last_grant_d;
      iss_seq_q    <= iss_seq_d;
      dataA_q      <= dataA_d;
      dataB_q      <= dataB_d;
      idx_q        <= idx_d;
      ret_seq_q    <= ret_seq_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_sum_q    <= rsp_sum_d;
      seq_err_q    <= seq_err_d;
      drain_q      <= drain_d;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.dataA      = dataA_q;
  assign bus.dataB      = dataB_q;
  assign bus.idx        = idx_q;
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_sum   = rsp_sum_q[0];
  assign bus.rsp1_sum   = rsp_sum_q[1];
  assign bus.seq_error  = seq_err_q;

endmodule

// File: tb/tb_sumador_arbitro.sv
// -----------------------------------------------------------------------------
// tb_sumador_arbitro
// Bench for sumador_arbitro with a behavioural LAT-stage adder model that is
// never reset (so stale in-flight results exist across a reset pulse) and can
// corrupt one client-0 tag (seq 1 -> seq 2).
// -----------------------------------------------------------------------------
module tb_sumador_arbitro;
  import sumador_pkg::*;

  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sumador_arbitro_if bus();

  sumador_arbitro #(.LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Adder model: LAT register stages, carry dropped, not reset.
  logic       corrupt = 1'b0;
  logic [3:0] ad_sum [LAT] = '{default: '0};
  logic [3:0] ad_idx [LAT] = '{default: '0};

  function automatic logic [3:0] tamper(input logic [3:0] t, input logic en);
    if (en && t == 4'b1001) return 4'b1010;
    return t;
  endfunction

  always @(posedge clk) begin
    ad_sum[0] <= bus.dataA + bus.dataB;
    ad_idx[0] <= tamper(bus.idx, corrupt);
    for (int i = 1; i < LAT; i++) begin
      ad_sum[i] <= ad_sum[i-1];
      ad_idx[i] <= ad_idx[i-1];
    end
  end

  assign bus.sum30_dd_out = ad_sum[LAT-1];
  assign bus.idx_dd_out   = ad_idx[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Scoreboard: one queue per client; entry due LAT+1 edges after transfer.
  typedef struct {
    logic [3:0] sum;
    int         due;
  } exp_t;

  exp_t q [2][$];
  int   cyc = 0;

  function automatic exp_t mk_exp(input logic [3:0] s, input int d);
    exp_t e;
    e.sum = s;
    e.due = d;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (bus.req0_valid && bus.req0_ready)
        q[0].push_back(mk_exp(4'(bus.req0_a + bus.req0_b), cyc + LAT + 2));
      if (bus.req1_valid && bus.req1_ready)
        q[1].push_back(mk_exp(4'(bus.req1_a + bus.req1_b), cyc + LAT + 2));
    end
  end

  // Anything in flight at reset is expected to be dropped.
  always @(posedge reset) begin
    q[0].delete();
    q[1].delete();
  end

  task automatic check_rsp(input int c, input logic v, input logic [3:0] s);
    logic due_now;
    due_now = (q[c].size() > 0) && (q[c][0].due == cyc);
    if (v || due_now) begin
      n_cmp++;
      if (v && due_now) begin
        if (s !== q[c][0].sum) begin
          n_bad++;
          $display("FAIL rsp%0d_sum @%0d: got %0d, expected %0d", c, cyc, s, q[c][0].sum);
        end
        void'(q[c].pop_front());
      end else if (v) begin
        n_bad++;
        $display("FAIL rsp%0d_spurious @%0d: got valid=1 sum=%0d, expected valid=0", c, cyc, s);
      end else begin
        n_bad++;
        $display("FAIL rsp%0d_missing @%0d: got valid=0, expected valid=1 sum=%0d", c, cyc, q[c][0].sum);
        void'(q[c].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    check_rsp(0, bus.rsp0_valid, bus.rsp0_sum);
    check_rsp(1, bus.rsp1_valid, bus.rsp1_sum);
  end

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (n) tick();
  endtask

  task automatic do_reset;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] gnt;
    logic [3:0] idx;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  initial begin
    logic [3:0] exp_a;
    logic [3:0] exp_b;

    // Applied right after a reset (last_grant = 1, all seq = 0).
    tv[0]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b01, 4'h8};
    tv[1]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b10, 4'hC};
    tv[2]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b01, 4'h9};
    tv[3]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b10, 4'hD};
    tv[4]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b01, 4'hA};
    tv[5]  = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd7,  4'd9, 2'b10, 4'hE};
    tv[6]  = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  4'd0, 2'b00, 4'h0};
    tv[7]  = '{1'b1, 4'd8,  4'd5,  1'b0, 4'd0,  4'd0, 2'b01, 4'hB};
    tv[8]  = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  4'd0, 2'b00, 4'h0};
    tv[9]  = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd3,  4'd4, 2'b10, 4'hF};
    tv[10] = '{1'b1, 4'd2,  4'd2,  1'b0, 4'd0,  4'd0, 2'b01, 4'h8};
    tv[11] = '{1'b1, 4'd15, 4'd15, 1'b1, 4'd15, 4'd1, 2'b10, 4'hC};
    tv[12] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  4'd0, 2'b00, 4'h0};

    // Reset state, with both clients requesting.
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    #2 reset = 1'b1;
    drive(1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 4'd3);
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_idx",    32'(bus.idx),        32'd0);
    chk("rst_dataA",  32'(bus.dataA),      32'd0);
    chk("rst_dataB",  32'(bus.dataB),      32'd0);
    chk("rst_rsp0",   32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1",   32'(bus.rsp1_valid), 32'd0);
    chk("rst_seqerr", 32'(bus.seq_error),  32'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Single issue from client 0, exact response latency.
    drive(1'b1, 4'd8, 4'd5, 1'b0, 4'd0, 4'd0);
    #1;
    chk("p1_ready0", 32'(bus.req0_ready), 32'd1);
    chk("p1_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    chk("p1_idx",   32'(bus.idx),   32'h8);
    chk("p1_dataA", 32'(bus.dataA), 32'd8);
    chk("p1_dataB", 32'(bus.dataB), 32'd5);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (LAT) tick();
    chk("p1_rsp0_early", 32'(bus.rsp0_valid), 32'd0);
    tick();
    chk("p1_rsp0_on",  32'(bus.rsp0_valid), 32'd1);
    chk("p1_rsp0_sum", 32'(bus.rsp0_sum),   32'd13);
    chk("p1_rsp1_off", 32'(bus.rsp1_valid), 32'd0);
    tick();
    chk("p1_rsp0_pulse", 32'(bus.rsp0_valid), 32'd0);
    idle(3);

    // Table: contention, idles, single issues, wrap, carry drop.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].v0, tv[i].a0, tv[i].b0, tv[i].v1, tv[i].a1, tv[i].b1);
      #1;
      chk($sformatf("tv%0d_gnt", i), 32'({bus.req1_ready, bus.req0_ready}), 32'(tv[i].gnt));
      exp_a = tv[i].gnt[0] ? tv[i].a0 : (tv[i].gnt[1] ? tv[i].a1 : 4'd0);
      exp_b = tv[i].gnt[0] ? tv[i].b0 : (tv[i].gnt[1] ? tv[i].b1 : 4'd0);
      tick();
      chk($sformatf("tv%0d_idx", i),   32'(bus.idx),   32'(tv[i].idx));
      chk($sformatf("tv%0d_dataA", i), 32'(bus.dataA), 32'(exp_a));
      chk($sformatf("tv%0d_dataB", i), 32'(bus.dataB), 32'(exp_b));
    end
    idle(LAT + 3);
    chk("tv_seqerr", 32'(bus.seq_error), 32'd0);

    // Five back-to-back issues from client 1: seq wraps 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b1, 4'(i), 4'd15);
      tick();
      chk($sformatf("wrap%0d_idx", i), 32'(bus.idx), 32'(4'hC | 4'(i % 4)));
      chk($sformatf("wrap%0d_dataA", i), 32'(bus.dataA), 32'(i));
    end
    idle(LAT + 3);
    chk("wrap_seqerr", 32'(bus.seq_error), 32'd0);

    // Corrupted tag on client 0: seq 1 returned as seq 2.
    do_reset();
    corrupt = 1'b1;
    drive(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 4'd0);
    repeat (3) tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("cor_seqerr_before", 32'(bus.seq_error), 32'd0);
    tick();
    chk("cor_seqerr_rise", 32'(bus.seq_error), 32'd1);
    idle(4);
    chk("cor_seqerr_sticky", 32'(bus.seq_error), 32'd1);
    corrupt = 1'b0;
    do_reset();
    chk("cor_seqerr_cleared", 32'(bus.seq_error), 32'd0);

    // Reset pulse with two results still inside the (unreset) adder.
    drive(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 4'd4);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();
    reset = 1'b1;
    drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 4'd5);
    #1;
    chk("drn_ready0_in_rst", 32'(bus.req0_ready), 32'd0);
    chk("drn_ready1_in_rst", 32'(bus.req1_ready), 32'd0);
    chk("drn_idx_in_rst",    32'(bus.idx),        32'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    #1 reset = 1'b0;
    repeat (LAT) tick();
    drive(1'b1, 4'd6, 4'd7, 1'b0, 4'd0, 4'd0);
    tick();
    chk("drn_idx_after", 32'(bus.idx), 32'h8);
    idle(LAT + 3);
    chk("drn_seqerr", 32'(bus.seq_error), 32'd0);

    chk("sb_empty0", 32'(q[0].size()), 32'd0);
    chk("sb_empty1", 32'(q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
